keypad4x4_scan: RTL and testbench

//   Scans a 4x4 passive key/button matrix: drives one row line low at a time,

---
 rtl/keypad4x4_scan.sv | 148 ++++++++++++++
 tb/tb_keypad4x4_scan.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/keypad4x4_scan.sv
`default_nettype none
// ============================================================================
// Module   : keypad4x4_scan
// Purpose  : Scans a 4x4 passive key matrix one row at a time. It drives one
//            row low, samples the four columns through a 2-flop synchroniser
//            and debounces every key independently. It presents the debounced
//            key state and a per-frame mask of the keys that changed.
// Ports    : clk         - system clock, all flops on the rising edge
//            resetn      - asynchronous active-low reset
//            row_n[3:0]  - active-low row drive, at most one bit low
//            col_n[3:0]  - active-low column sense, asynchronous
//            keybits[15:0]     - debounced state, 1 = pressed, bit 4*row+col
//            frame_done        - 1-cycle pulse after row 3 has been sampled
//            change_mask[15:0] - keys that toggled this frame, only while
//                                frame_done is high
// Revision : 1.0 - initial release
// ============================================================================
module keypad4x4_scan #(
  parameter int SETTLE_CYCLES  = 32,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  output logic [15:0] keybits,
  output logic        frame_done,
  output logic [15:0] change_mask
);

  localparam int DWELL_W = $clog2(SETTLE_CYCLES);
  localparam int CNT_W   = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DWELL_W-1:0] LAST_DWELL = DWELL_W'(SETTLE_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LIMIT  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [1:0]         LAST_ROW   = 2'd3;

  // Synchroniser
  logic [3:0] col_meta_q, col_meta_d;
  logic [3:0] col_sync_q, col_sync_d;

  // Scan position. live_q is low only for the first cycle after reset, which
  // lets the first edge display row 0 without also advancing the dwell count.
  logic               live_q, live_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [1:0]         row_q, row_d;
  logic [3:0]         row_n_q, row_n_d;

  // Debounce state
  logic [15:0]            keybits_q, keybits_d;
  logic [15:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]            changed_q, changed_d;

  // Frame outputs
  logic        frame_done_q, frame_done_d;
  logic [15:0] change_mask_q, change_mask_d;

  logic [3:0] w_raw;
  logic       w_sample;

  assign w_raw    = ~col_sync_q;
  assign w_sample = live_q && (dwell_q == LAST_DWELL);

  always_comb begin
    col_meta_d    = col_n;
    col_sync_d    = col_meta_q;
    live_d        = 1'b1;
    dwell_d       = dwell_q;
    row_d         = row_q;
    keybits_d     = keybits_q;
    cnt_d         = cnt_q;
    changed_d     = changed_q;
    frame_done_d  = 1'b0;
    change_mask_d = 16'h0000;

    if (live_q) begin
      if (dwell_q == LAST_DWELL) begin
        dwell_d = '0;
        row_d   = row_q + 2'd1;
      end else begin
        dwell_d = dwell_q + DWELL_ONE;
      end
    end

    // Row drive is registered from the next position, so it always matches
    // the row whose dwell is being counted.
    row_n_d = ~(4'b0001 << row_d);

    if (w_sample) begin
      for (int c = 0; c < 4; c++) begin
        if (w_raw[c] == keybits_q[4*int'(row_q) + c]) begin
          cnt_d[4*int'(row_q) + c] = '0;
        end else if ((cnt_q[4*int'(row_q) + c] + CNT_ONE) == CNT_LIMIT) begin
          keybits_d[4*int'(row_q) + c] = w_raw[c];
          cnt_d[4*int'(row_q) + c]     = '0;
          changed_d[4*int'(row_q) + c] = 1'b1;
        end else begin
          cnt_d[4*int'(row_q) + c] = cnt_q[4*int'(row_q) + c] + CNT_ONE;
        end
      end

      // Row 3 closes the frame: publish the accumulated changes (including
      // any row-3 changes made on this same edge) and start afresh.
      if (row_q == LAST_ROW) begin
        frame_done_d  = 1'b1;
        change_mask_d = changed_d;
        changed_d     = 16'h0000;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_meta_q    <= 4'hF;
      col_sync_q    <= 4'hF;
      live_q        <= 1'b0;
      dwell_q       <= '0;
      row_q         <= 2'd0;
      row_n_q       <= 4'b1111;
      keybits_q     <= 16'h0000;
      cnt_q         <= '0;
      changed_q     <= 16'h0000;
      frame_done_q  <= 1'b0;
      change_mask_q <= 16'h0000;
    end else begin
      col_meta_q    <= col_meta_d;
      col_sync_q    <= col_sync_d;
      live_q        <= live_d;
      dwell_q       <= dwell_d;
      row_q         <= row_d;
      row_n_q       <= row_n_d;
      keybits_q     <= keybits_d;
      cnt_q         <= cnt_d;
      changed_q     <= changed_d;
      frame_done_q  <= frame_done_d;
      change_mask_q <= change_mask_d;
    end
  end

  assign row_n       = row_n_q;
  assign keybits     = keybits_q;
  assign frame_done  = frame_done_q;
  assign change_mask = change_mask_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad4x4_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad4x4_scan
// Purpose  : Self-checking bench for keypad4x4_scan with SETTLE_CYCLES=8 and
//            DEBOUNCE_SCANS=3. A frame-level key model pushes the expected
//            keybits/change_mask for each frame into a queue. Each frame_done
//            pops one entry and compares it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad4x4_scan;

  localparam int SETTLE = 8;
  localparam int DEB    = 3;
  localparam int FRAME  = 4 * SETTLE;

  logic        clk;
  logic        resetn;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] keybits;
  logic        frame_done;
  logic [15:0] change_mask;

  logic [15:0] pressed;

  keypad4x4_scan #(
    .SETTLE_CYCLES (SETTLE),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .row_n      (row_n),
    .col_n      (col_n),
    .keybits    (keybits),
    .frame_done (frame_done),
    .change_mask(change_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Diode-isolated matrix: a pressed key pulls its column low while its row
  // is driven low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row_n[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (pressed[4*r + c]) col_n[c] = 1'b0;
        end
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] keys;
    logic [15:0] mask;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] m_keys;
  int          m_cnt[16];

  task automatic model_reset();
    m_keys = 16'h0000;
    for (int k = 0; k < 16; k++) m_cnt[k] = 0;
  endtask

  // Call on a frame_done cycle, or on the first cycle of a scan. It applies
  // p for one frame and checks the result at the next frame_done.
  task automatic run_frame(input logic [15:0] p, input string tag);
    exp_t e;
    exp_t got_e;
    bit   seen;
    pressed = p;
    e.mask  = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      if (p[k] == m_keys[k]) begin
        m_cnt[k] = 0;
      end else if (m_cnt[k] + 1 == DEB) begin
        m_keys[k] = p[k];
        m_cnt[k]  = 0;
        e.mask[k] = 1'b1;
      end else begin
        m_cnt[k]++;
      end
    end
    e.keys = m_keys;
    sb_q.push_back(e);

    seen = 1'b0;
    for (int i = 0; i < FRAME + 8; i++) begin
      @(negedge clk);
      if (i == 0) chk({tag, "_mask_idle"}, {16'h0, change_mask}, 32'h0);
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    got_e = sb_q.pop_front();
    if (!seen) begin
      chk({tag, "_frame_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_keybits"}, {16'h0, keybits}, {16'h0, got_e.keys});
      chk({tag, "_mask"}, {16'h0, change_mask}, {16'h0, got_e.mask});
      chk({tag, "_row_wrap"}, {28'h0, row_n}, 32'hE);
    end
  endtask

  initial begin
    pressed = 16'h0000;
    resetn  = 1'b0;
    model_reset();

    // 1. Reset state, then the idle scan sequence over two frames.
    repeat (3) @(negedge clk);
    chk("rst_row_n", {28'h0, row_n}, 32'hF);
    chk("rst_keybits", {16'h0, keybits}, 32'h0);
    chk("rst_frame_done", {31'h0, frame_done}, 32'h0);
    chk("rst_mask", {16'h0, change_mask}, 32'h0);
    resetn = 1'b1;
    for (int i = 0; i <= 2 * FRAME; i++) begin
      @(negedge clk);
      chk("scan_row_n", {28'h0, row_n}, {28'h0, ~(4'b0001 << ((i / SETTLE) % 4))});
      chk("scan_frame_done", {31'h0, frame_done}, {31'h0, (i > 0) && (i % FRAME == 0)});
      if (frame_done) begin
        chk("idle_keybits", {16'h0, keybits}, 32'h0);
        chk("idle_mask", {16'h0, change_mask}, 32'h0);
      end
    end

    // 2. Hold key 6 (row 1, column 2).
    for (int f = 0; f < 4; f++) run_frame(16'h0040, "hold6");
    // 4. Release it.
    for (int f = 0; f < 4; f++) run_frame(16'h0000, "rel6");
    // 3. A two-frame press is rejected.
    for (int f = 0; f < 2; f++) run_frame(16'h0040, "bounce");
    for (int f = 0; f < 3; f++) run_frame(16'h0000, "bounce_rel");
    // 5. Keys 0 and 15 together, then released together.
    for (int f = 0; f < 4; f++) run_frame(16'h8001, "dual");
    for (int f = 0; f < 3; f++) run_frame(16'h0000, "dual_rel");

    // 6. Reset in the middle of row 2 while key 6 is held.
    for (int f = 0; f < 4; f++) run_frame(16'h0040, "pre_rst");
    repeat (2 * SETTLE + 4) @(negedge clk);
    chk("mid_row2", {28'h0, row_n}, 32'hB);
    resetn = 1'b0;
    #1;
    chk("async_row_n", {28'h0, row_n}, 32'hF);
    chk("async_keybits", {16'h0, keybits}, 32'h0);
    chk("async_frame_done", {31'h0, frame_done}, 32'h0);
    chk("async_mask", {16'h0, change_mask}, 32'h0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("restart_row_n", {28'h0, row_n}, 32'hE);
    model_reset();
    for (int f = 0; f < 4; f++) run_frame(16'h0040, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
